// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction-memory request/ack, decode handoff
// and execute redirect, seen from the sequencer (master) or its peers.
interface fetch_sequencer_if #(
    parameter int XLEN = 64
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            dec_valid;
    logic [31:0]     dec_instr;
    logic [XLEN-1:0] dec_pc;
    logic            dec_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output dec_valid,
        output dec_instr,
        output dec_pc,
        input  dec_ready,
        input  redirect_valid,
        input  redirect_target
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  dec_valid,
        input  dec_instr,
        input  dec_pc,
        output dec_ready,
        output redirect_valid,
        output redirect_target
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: PC, one outstanding imem request,
// single-entry decode handoff, redirect squash and misalignment halt.
module fetch_sequencer #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus,
    output logic              fault,
    output logic [XLEN-1:0]   instr_count
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        ISSUE,
        HALT
    } stateT;

    stateT           state;
    stateT           stateNext;

    logic [XLEN-1:0] pcQ;
    logic [XLEN-1:0] pcNext;
    logic [XLEN-1:0] addrQ;
    logic [31:0]     instrQ;
    logic [XLEN-1:0] decPcQ;
    logic [XLEN-1:0] countQ;
    logic            squashQ;
    logic            squashNext;
    logic            haltPendQ;
    logic            haltPendNext;
    logic            faultQ;
    logic            faultNext;

    logic            redir;
    logic            aligned;
    logic            loadAddr;
    logic            loadDec;
    logic            countUp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext    = state;
        pcNext       = pcQ;
        squashNext   = squashQ;
        haltPendNext = haltPendQ;
        faultNext    = faultQ;
        loadAddr     = 1'b0;
        loadDec      = 1'b0;
        countUp      = 1'b0;
        // Once a fault is latched, the block is on its way to HALT and
        // further redirects have nowhere to go.
        redir   = bus.redirect_valid && !faultQ;
        aligned = (bus.redirect_target[1:0] == 2'b00);

        unique case (state)
            FETCH: begin
                if (redir && aligned) begin
                    pcNext = bus.redirect_target;
                end else if (redir) begin
                    faultNext = 1'b1;
                    stateNext = HALT;
                end else begin
                    loadAddr  = 1'b1;
                    stateNext = WAIT;
                end
            end

            WAIT: begin
                if (bus.imem_ack) begin
                    squashNext   = 1'b0;
                    haltPendNext = 1'b0;
                    if (redir && !aligned) begin
                        faultNext = 1'b1;
                        stateNext = HALT;
                    end else if (haltPendQ) begin
                        stateNext = HALT;
                    end else if (redir) begin
                        pcNext    = bus.redirect_target;
                        stateNext = FETCH;
                    end else if (squashQ) begin
                        stateNext = FETCH;
                    end else begin
                        loadDec   = 1'b1;
                        pcNext    = pcQ + XLEN'(4);
                        stateNext = ISSUE;
                    end
                end else if (redir && aligned) begin
                    // The bus request cannot be withdrawn; mark it stale.
                    pcNext     = bus.redirect_target;
                    squashNext = 1'b1;
                end else if (redir) begin
                    faultNext    = 1'b1;
                    haltPendNext = 1'b1;
                    squashNext   = 1'b1;
                end
            end

            ISSUE: begin
                countUp = bus.dec_ready;
                if (redir && aligned) begin
                    pcNext    = bus.redirect_target;
                    stateNext = FETCH;
                end else if (redir) begin
                    faultNext = 1'b1;
                    stateNext = HALT;
                end else if (bus.dec_ready) begin
                    stateNext = FETCH;
                end
            end

            HALT: begin
                stateNext = HALT;
            end

            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcQ       <= RESET_PC;
            addrQ     <= RESET_PC;
            instrQ    <= 32'h0;
            decPcQ    <= '0;
            countQ    <= '0;
            squashQ   <= 1'b0;
            haltPendQ <= 1'b0;
            faultQ    <= 1'b0;
        end else begin
            pcQ       <= pcNext;
            squashQ   <= squashNext;
            haltPendQ <= haltPendNext;
            faultQ    <= faultNext;
            if (loadAddr) begin
                addrQ <= pcQ;
            end
            if (loadDec) begin
                instrQ <= bus.imem_rdata;
                decPcQ <= pcQ;
            end
            if (countUp) begin
                countQ <= countQ + XLEN'(1);
            end
        end
    end

    assign bus.imem_req  = (state == WAIT);
    assign bus.imem_addr = addrQ;
    assign bus.dec_valid = (state == ISSUE);
    assign bus.dec_instr = instrQ;
    assign bus.dec_pc    = decPcQ;
    assign fault         = faultQ;
    assign instr_count   = countQ;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic,
// checked every cycle against a transaction-level fetch model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fault;
    logic [63:0] instrCount;

    fetch_sequencer_if #(.XLEN(64)) bus ();

    fetch_sequencer #(
        .XLEN    (64),
        .RESET_PC(64'h0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fault      (fault),
        .instr_count(instrCount)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE0000;
    endfunction

    always_comb bus.imem_rdata = memWord(bus.imem_addr);

    int checks = 0;
    int failures = 0;
    logic cmpEn = 1'b0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: one outstanding fetch, one held decode item, next fetch PC.
    logic        mBusy, mWrong, mHaltAfter, mHold, mHalted, mFault;
    logic [63:0] mAddr, mNext, mItemPc, mCount;
    logic [31:0] mItemInstr;

    task automatic modelReset();
        mBusy = 0; mWrong = 0; mHaltAfter = 0; mHold = 0;
        mHalted = 0; mFault = 0;
        mAddr = 64'h0; mNext = 64'h0; mItemPc = 64'h0; mCount = 64'h0;
        mItemInstr = 32'h0;
    endtask

    task automatic modelStep(input logic a, input logic r, input logic v,
                             input logic [63:0] t);
        logic take;
        logic al;
        take = v && !mFault;
        al = (t[1:0] == 2'b00);
        if (mHalted) begin
            mHalted = 1;
        end else if (mBusy) begin
            if (a) begin
                mBusy = 0;
                if (take && !al) begin
                    mFault = 1; mHalted = 1;
                end else if (mHaltAfter) begin
                    mHalted = 1;
                end else if (take) begin
                    mNext = t;
                end else if (!mWrong) begin
                    mHold = 1;
                    mItemPc = mAddr;
                    mItemInstr = memWord(mAddr);
                    mNext = mAddr + 64'd4;
                end
                mWrong = 0; mHaltAfter = 0;
            end else if (take) begin
                mWrong = 1;
                if (al) mNext = t;
                else begin mFault = 1; mHaltAfter = 1; end
            end
        end else if (mHold) begin
            if (r) mCount = mCount + 64'd1;
            if (take) begin
                mHold = 0;
                if (al) mNext = t;
                else begin mFault = 1; mHalted = 1; end
            end else if (r) begin
                mHold = 0;
            end
        end else begin
            if (take) begin
                if (al) mNext = t;
                else begin mFault = 1; mHalted = 1; end
            end else begin
                mBusy = 1;
                mAddr = mNext;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmpEn) begin
            check("imem_req", bus.imem_req, mBusy);
            check("imem_addr", bus.imem_addr, mAddr);
            check("dec_valid", bus.dec_valid, mHold);
            check("dec_instr", bus.dec_instr, mItemInstr);
            check("dec_pc", bus.dec_pc, mItemPc);
            check("fault", fault, mFault);
            check("instr_count", instrCount, mCount);
        end
    end

    // Event log for the literal scenario checks.
    int          cyc = 0;
    logic        prevReq = 1'b0;
    int          reqCycles = 0;
    logic [63:0] reqStarts[$];
    logic [63:0] hsPc[$];
    int          hsCyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.imem_req === 1'b1) begin
            reqCycles++;
            if (prevReq !== 1'b1) reqStarts.push_back(bus.imem_addr);
        end
        prevReq = bus.imem_req;
        if (bus.dec_valid === 1'b1 && bus.dec_ready === 1'b1) begin
            hsPc.push_back(bus.dec_pc);
            hsCyc.push_back(cyc);
        end
    end

    task automatic clearLog();
        reqCycles = 0;
        reqStarts.delete();
        hsPc.delete();
        hsCyc.delete();
    endtask

    task automatic step(input logic a, input logic r, input logic v,
                        input logic [63:0] t);
        bus.imem_ack = a;
        bus.dec_ready = r;
        bus.redirect_valid = v;
        bus.redirect_target = t;
        @(posedge clk);
        #1;
        if (reset) modelReset();
        else modelStep(a, r, v, t);
    endtask

    task automatic doReset();
        reset = 1'b1;
        step(1'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom});
        reset = 1'b0;
    endtask

    function automatic logic [63:0] randTarget();
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) return {$urandom, $urandom} | 64'h1;
        if (k == 1) return {$urandom, $urandom} | 64'h2;
        if (k == 2) return 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
        return {48'h0, 16'($urandom)} & ~64'h3;
    endfunction

    initial begin
        bus.imem_ack = 0;
        bus.dec_ready = 0;
        bus.redirect_valid = 0;
        bus.redirect_target = 64'h0;
        @(posedge clk);
        #1;
        doReset();
        cmpEn = 1'b1;

        check("rst_req", bus.imem_req, 0);
        check("rst_addr", bus.imem_addr, 64'h0);
        check("rst_valid", bus.dec_valid, 0);
        check("rst_instr", bus.dec_instr, 0);
        check("rst_count", instrCount, 0);

        // Back-to-back fetches, ack and ready always high.
        clearLog();
        for (int i = 0; i < 9; i++) step(1, 1, 0, 64'h0);
        check("seq_count", instrCount, 64'd3);
        check("seq_nreq", reqStarts.size(), 3);
        check("seq_req0", reqStarts.size() > 0 ? reqStarts[0] : '1, 64'h0);
        check("seq_req1", reqStarts.size() > 1 ? reqStarts[1] : '1, 64'h4);
        check("seq_req2", reqStarts.size() > 2 ? reqStarts[2] : '1, 64'h8);
        check("seq_nhs", hsPc.size(), 3);
        check("seq_pc2", hsPc.size() > 2 ? hsPc[2] : '1, 64'h8);
        check("seq_gap", hsCyc.size() > 2 ? 64'(hsCyc[2] - hsCyc[1]) : '1, 64'd3);

        // Slow ack on 0x10, then decode stalls for four cycles.
        doReset();
        clearLog();
        step(0, 0, 1, 64'h10);
        step(0, 0, 0, 64'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 64'h0);
        step(1, 0, 0, 64'h0);
        check("slow_reqcyc", reqCycles, 5);
        check("slow_reqaddr", reqStarts.size() > 0 ? reqStarts[0] : '1, 64'h10);
        check("slow_valid", bus.dec_valid, 1);
        check("slow_instr", bus.dec_instr, 32'hC0DE0010);
        check("slow_pc", bus.dec_pc, 64'h10);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 64'h0);
            check("stall_valid", bus.dec_valid, 1);
            check("stall_pc", bus.dec_pc, 64'h10);
            check("stall_req", bus.imem_req, 0);
            check("stall_count", instrCount, 0);
        end
        step(0, 1, 0, 64'h0);
        check("stall_done", instrCount, 64'd1);

        // Redirect while waiting on 0x8; the stale word must vanish.
        doReset();
        for (int i = 0; i < 6; i++) step(1, 1, 0, 64'h0);
        clearLog();
        step(0, 1, 0, 64'h0);
        step(0, 1, 1, 64'h200);
        check("sq_addr_held", bus.imem_addr, 64'h8);
        step(0, 1, 0, 64'h0);
        step(0, 1, 0, 64'h0);
        step(1, 1, 0, 64'h0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 64'h0);
        check("sq_nreq", reqStarts.size(), 2);
        check("sq_req1", reqStarts.size() > 1 ? reqStarts[1] : '1, 64'h200);
        check("sq_nhs", hsPc.size(), 1);
        check("sq_hspc", hsPc.size() > 0 ? hsPc[0] : '1, 64'h200);
        check("sq_count", instrCount, 64'd3);

        // Redirect coinciding with the decode handshake.
        doReset();
        step(1, 0, 0, 64'h0);
        step(1, 0, 0, 64'h0);
        step(0, 1, 1, 64'h100);
        check("rdhs_count", instrCount, 64'd1);
        step(0, 0, 0, 64'h0);
        check("rdhs_req", bus.imem_req, 1);
        check("rdhs_addr", bus.imem_addr, 64'h100);

        // Misaligned redirect during that fetch: finish it, then halt.
        step(0, 0, 1, 64'h102);
        check("mis_fault", fault, 1);
        check("mis_req", bus.imem_req, 1);
        step(0, 0, 0, 64'h0);
        step(1, 1, 0, 64'h0);
        clearLog();
        for (int i = 0; i < 6; i++) step(1, 1, 1, 64'(4 * i));
        check("halt_reqcyc", reqCycles, 0);
        check("halt_nhs", hsPc.size(), 0);
        check("halt_fault", fault, 1);
        doReset();
        check("halt_clr", fault, 0);
        step(1, 1, 0, 64'h0);
        check("resume_req", bus.imem_req, 1);
        check("resume_addr", bus.imem_addr, 64'h0);

        // Random traffic.
        for (int blk = 0; blk < 40; blk++) begin
            int ackPct;
            int rdyPct;
            ackPct = $urandom_range(15, 100);
            rdyPct = $urandom_range(15, 100);
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 399) == 0 ||
                    (mHalted && $urandom_range(0, 9) == 0)) begin
                    doReset();
                end else begin
                    step($urandom_range(0, 99) < ackPct,
                         $urandom_range(0, 99) < rdyPct,
                         $urandom_range(0, 99) < 6,
                         randTarget());
                end
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction fetch controller for the RV64 core front end. It holds the program counter, fetches 32-bit instructions over a request/acknowledge instruction-memory port and presents each instruction, with its PC, to decode (register file read and immediate generation) through a valid/ready handshake. It accepts PC redirects from execute (branch, jal, jalr targets) and discards wrong-path fetches. It also counts retired-to-decode instructions.

## Interface
- XLEN, 64, PC and address width
- RESET_PC, 64'h0, PC value loaded by reset
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock with reset=1 fully initialises the block
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  XLEN  fetch address; stable while imem_req=1
- imem_ack  in  1  read data valid this cycle; ignored when imem_req=0
- imem_rdata  in  32  instruction word, sampled when imem_req&imem_ack
- dec_valid  out  1  dec_instr/dec_pc valid for decode
- dec_instr  out  32  instruction word
- dec_pc  out  XLEN  address of dec_instr
- dec_ready  in  1  decode accepts when dec_valid&dec_ready
- redirect_valid  in  1  one-cycle pulse: next fetch from redirect_target
- redirect_target  in  XLEN  redirect address; must be 4-byte aligned
- fault  out  1  sticky misaligned-target flag
- instr_count  out  XLEN  number of decode handshakes since reset

## Operation
- Reset values: state=FETCH, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, dec_valid=0, dec_instr=32'h0, dec_pc=0, fault=0, instr_count=0, squash=0.
- States: FETCH, WAIT, ISSUE, HALT.
- FETCH: imem_req=0, one-cycle setup; next WAIT with imem_addr=pc.
- WAIT: imem_req=1, imem_addr=pc. On imem_ack: if squash=0, load dec_instr=imem_rdata, dec_pc=pc, pc<=pc+4, go ISSUE; if squash=1, discard data, clear squash, go FETCH (pc already holds redirect target).
- ISSUE: dec_valid=1, dec_instr/dec_pc held stable until handshake. On dec_valid&dec_ready: instr_count+=1, go FETCH.
- Redirect (any state except HALT), aligned target (redirect_target[1:0]==2'b00):
  - pc<=redirect_target; redirect takes priority over pc+4 in the same cycle.
  - In WAIT without ack: set squash; imem_req stays asserted on the old address until ack (no abort).
  - In WAIT with ack same cycle: discard data, go FETCH.
  - In ISSUE: dec_valid deasserts next cycle, go FETCH; if dec_ready same cycle the handshake completes and is counted.
  - In FETCH: go FETCH again (re-setup) with new pc.
- Redirect with target[1:0]!=0: fault<=1, go HALT; an in-flight request in WAIT is completed (waited for ack) before HALT and its data discarded; dec_valid=0 in HALT.
- HALT: imem_req=0, dec_valid=0; only reset exits; redirects ignored.
- pc+4 and instr_count wrap modulo 2^XLEN without flag.

## Timing
- Minimum 3 cycles per instruction with single-cycle ack and immediate dec_ready: FETCH, WAIT (ack), ISSUE (ready).
- imem_ack may arrive in the first WAIT cycle; imem_rdata sampled on that edge, dec_valid=1 the following cycle.
- Redirect pulse at cycle N: fetch from target is the next imem_req after cycle N; no wrong-path instruction ever reaches dec_valid after N.
- instr_count updates on the edge of the handshake; visible next cycle.
- Reset mid-WAIT abandons the request: imem_req=0 the cycle after reset; memory must drop a late ack.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, RESET_PC=0, ack and dec_ready always 1 -> imem_addr sequence 0,4,8; dec_pc 0,4,8 every 3 cycles; instr_count=3 after third handshake.
- Ack delayed 5 cycles on addr 0x10 -> imem_req and imem_addr=0x10 held 5 cycles; dec_instr equals rdata at ack; dec_valid one cycle after ack.
- dec_ready low 4 cycles in ISSUE -> dec_valid, dec_instr, dec_pc constant; no new imem_req; instr_count unchanged.
- Redirect to 0x200 while WAIT on 0x8 with ack 3 cycles later -> that data never on dec_instr; next imem_addr=0x200; dec_pc=0x200.
- Redirect to 0x100 and dec_ready in same ISSUE cycle -> instr_count increments once; next fetch 0x100.
- Redirect to 0x102 -> fault=1, HALT, no further imem_req or dec_valid; reset clears fault, fetch resumes at RESET_PC.
